// File: rtl/branch_predict_if.sv
// branch_predict_if: decode/execute signal bundle between the pipeline and the branch predictor.
interface branch_predict_if #(
  parameter int BP_ADDR_BITS = 12,
  parameter int RAS_DEPTH = 8
);
  localparam int RP_BITS = $clog2(RAS_DEPTH);
  logic ready_o;
  logic D_valid_i;
  logic [31:0] D_PC_i;
  logic D_isBranch_i;
  logic D_isJump_i;
  logic D_isCall_i;
  logic D_isReturn_i;
  logic [31:0] D_target_i;
  logic D_predictPC_o;
  logic [31:0] D_PCprediction_o;
  logic [BP_ADDR_BITS-1:0] D_bhtIndex_o;
  logic [RP_BITS-1:0] D_rasPtr_o;
  logic [RP_BITS:0] D_rasCount_o;
  logic E_update_i;
  logic [BP_ADDR_BITS-1:0] E_bhtIndex_i;
  logic E_taken_i;
  logic E_mispredict_i;
  logic [RP_BITS-1:0] E_rasPtr_i;
  logic [RP_BITS:0] E_rasCount_i;
  modport master (
    input ready_o, D_predictPC_o, D_PCprediction_o, D_bhtIndex_o, D_rasPtr_o, D_rasCount_o,
    output D_valid_i, D_PC_i, D_isBranch_i, D_isJump_i, D_isCall_i, D_isReturn_i, D_target_i,
    output E_update_i, E_bhtIndex_i, E_taken_i, E_mispredict_i, E_rasPtr_i, E_rasCount_i
  );
  modport slave (
    output ready_o, D_predictPC_o, D_PCprediction_o, D_bhtIndex_o, D_rasPtr_o, D_rasCount_o,
    input D_valid_i, D_PC_i, D_isBranch_i, D_isJump_i, D_isCall_i, D_isReturn_i, D_target_i,
    input E_update_i, E_bhtIndex_i, E_taken_i, E_mispredict_i, E_rasPtr_i, E_rasCount_i
  );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: gshare direction table plus circular return-address stack with checkpoint restore.
module branch_predict_unit #(
  parameter int BP_ADDR_BITS = 12,
  parameter int BH_BITS = 9,
  parameter int CTR_BITS = 2,
  parameter int RAS_DEPTH = 8
) (
  input logic clk_i,
  input logic reset_i,
  branch_predict_if.slave bp
);
  localparam int BHT_SIZE = 1 << BP_ADDR_BITS;
  localparam int RP_BITS = $clog2(RAS_DEPTH);
  localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CMAX = '1;
  localparam logic [RP_BITS:0] FULL = (RP_BITS + 1)'(RAS_DEPTH);
  typedef enum logic {INIT, RUN} state_e;
  state_e state_q, state_d;
  logic [BP_ADDR_BITS-1:0] sweep_q, sweep_d;
  logic [BH_BITS-1:0] hist_q, hist_d;
  logic [RP_BITS-1:0] tp_q, tp_d;
  logic [RP_BITS:0] cnt_q, cnt_d;
  logic [CTR_BITS-1:0] bht_q [BHT_SIZE];
  logic [31:0] ras_q [RAS_DEPTH];
  logic [BP_ADDR_BITS-1:0] idx, wr_idx;
  logic [CTR_BITS-1:0] ctr_e, wr_val;
  logic [RP_BITS-1:0] ras_wa;
  logic [31:0] ret_addr;
  logic bht_we, ras_we, taken, push, pop, swap, ras_empty;
  assign idx = bp.D_PC_i[BP_ADDR_BITS+1:2] ^ (BP_ADDR_BITS'(hist_q) << (BP_ADDR_BITS - BH_BITS));
  assign taken = bht_q[idx][CTR_BITS-1] & (state_q == RUN);
  assign ctr_e = bht_q[bp.E_bhtIndex_i];
  assign ras_empty = cnt_q == '0;
  assign push = bp.D_valid_i & bp.D_isCall_i & ~bp.D_isReturn_i;
  assign pop = bp.D_valid_i & bp.D_isReturn_i & ~bp.D_isCall_i & ~ras_empty;
  assign swap = bp.D_valid_i & bp.D_isCall_i & bp.D_isReturn_i;
  assign ret_addr = bp.D_PC_i + 32'd4;
  assign ras_we = push | swap;
  assign ras_wa = push ? tp_q + 1'b1 : tp_q;
  assign bp.ready_o = state_q == RUN;
  assign bp.D_bhtIndex_o = idx;
  assign bp.D_predictPC_o = bp.D_valid_i & (bp.D_isJump_i | (bp.D_isBranch_i & taken))
                          & ~(bp.D_isReturn_i & ras_empty);
  assign bp.D_PCprediction_o = bp.D_isReturn_i ? ras_q[tp_q] : bp.D_target_i;
  assign bp.D_rasPtr_o = reset_i ? '0 : tp_q;
  assign bp.D_rasCount_o = reset_i ? '0 : cnt_q;
  always_comb begin
    state_d = (state_q == INIT && sweep_q == '1) ? RUN : state_q;
    sweep_d = state_q == INIT ? sweep_q + 1'b1 : sweep_q;
    hist_d = (state_q == RUN && bp.E_update_i)
           ? (hist_q >> 1) | (BH_BITS'(bp.E_taken_i) << (BH_BITS - 1)) : hist_q;
    bht_we = ~reset_i & (state_q == INIT | bp.E_update_i);
    wr_idx = state_q == INIT ? sweep_q : bp.E_bhtIndex_i;
    wr_val = state_q == INIT ? WNT
           : bp.E_taken_i ? ctr_e + CTR_BITS'(ctr_e != CMAX) : ctr_e - CTR_BITS'(ctr_e != '0);
    tp_d = bp.E_mispredict_i ? bp.E_rasPtr_i : push ? tp_q + 1'b1 : pop ? tp_q - 1'b1 : tp_q;
    cnt_d = bp.E_mispredict_i ? bp.E_rasCount_i
          : push ? cnt_q + (RP_BITS + 1)'(cnt_q != FULL) : pop ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= INIT;
      sweep_q <= '0;
      hist_q <= '0;
      tp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      hist_q <= hist_d;
      tp_q <= tp_d;
      cnt_q <= cnt_d;
    end
  end
  // Table and stack storage are never reset; the sweep defines the table contents.
  always_ff @(posedge clk_i) begin
    if (bht_we) bht_q[wr_idx] <= wr_val;
    if (ras_we) ras_q[ras_wa] <= ret_addr;
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed plan plus randomized traffic against a behavioural predictor model.
module tb_branch_predict_unit;
  localparam int BA = 7;
  localparam int BH = 5;
  localparam int CB = 2;
  localparam int RD = 4;
  localparam int RPB = 2;
  localparam int BHT = 1 << BA;
  localparam int WNT = (1 << (CB - 1)) - 1;
  localparam int CMAX = (1 << CB) - 1;
  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;
  branch_predict_if #(.BP_ADDR_BITS(BA), .RAS_DEPTH(RD)) bp ();
  branch_predict_unit #(.BP_ADDR_BITS(BA), .BH_BITS(BH), .CTR_BITS(CB), .RAS_DEPTH(RD)) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .bp(bp)
  );
  int m_ctr [BHT];
  logic [31:0] m_ent [RD];
  int m_hist, m_tp, m_cnt, m_init;
  bit m_ready, m_known;
  int n_cmp, n_bad;
  int cp_tp, cp_cnt;
  logic [31:0] hist_exp [6] = '{32'h40, 32'h60, 32'h70, 32'h78, 32'h3C, 32'h1C};
  logic [31:0] ovf_exp [4] = '{32'h54, 32'h44, 32'h34, 32'h24};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int m_idx(input logic [31:0] pc);
    return (int'(pc >> 2) ^ (m_hist << (BA - BH))) & (BHT - 1);
  endfunction
  function automatic logic [31:0] pc_for(input int i);
    return 32'(((i ^ (m_hist << (BA - BH))) & (BHT - 1)) << 2);
  endfunction
  function automatic bit m_pred();
    return bp.D_valid_i && (bp.D_isJump_i ||
           (bp.D_isBranch_i && m_ready && m_ctr[m_idx(bp.D_PC_i)] >= (1 << (CB - 1))))
           && !(bp.D_isReturn_i && m_cnt == 0);
  endfunction
  task automatic apply();
    int c;
    if (reset_i) begin
      m_known = 1; m_ready = 0; m_init = 0; m_hist = 0; m_tp = 0; m_cnt = 0;
    end else begin
      if (!m_ready) begin
        m_init++;
        if (m_init == BHT) begin
          foreach (m_ctr[i]) m_ctr[i] = WNT;
          m_ready = 1;
        end
      end else if (bp.E_update_i) begin
        c = m_ctr[bp.E_bhtIndex_i];
        m_ctr[bp.E_bhtIndex_i] = bp.E_taken_i ? (c < CMAX ? c + 1 : c) : (c > 0 ? c - 1 : c);
        m_hist = (m_hist >> 1) | (int'(bp.E_taken_i) << (BH - 1));
      end
      if (bp.D_valid_i) begin
        if (bp.D_isCall_i && bp.D_isReturn_i) m_ent[m_tp] = bp.D_PC_i + 4;
        else if (bp.D_isCall_i) begin
          m_tp = (m_tp + 1) % RD;
          m_ent[m_tp] = bp.D_PC_i + 4;
          m_cnt = m_cnt < RD ? m_cnt + 1 : RD;
        end else if (bp.D_isReturn_i && m_cnt > 0) begin
          m_tp = (m_tp + RD - 1) % RD;
          m_cnt--;
        end
      end
      if (bp.E_mispredict_i) begin
        m_tp = int'(bp.E_rasPtr_i);
        m_cnt = int'(bp.E_rasCount_i);
      end
    end
  endtask
  task automatic step();
    bit p;
    #1;
    if (m_known) begin
      p = m_pred();
      chk("ready", 32'(bp.ready_o), 32'(m_ready));
      chk("index", 32'(bp.D_bhtIndex_o), m_idx(bp.D_PC_i));
      chk("predict", 32'(bp.D_predictPC_o), 32'(p));
      if (p) chk("target", bp.D_PCprediction_o, bp.D_isReturn_i ? m_ent[m_tp] : bp.D_target_i);
      chk("ras_ptr", 32'(bp.D_rasPtr_o), reset_i ? 0 : m_tp);
      chk("ras_cnt", 32'(bp.D_rasCount_o), reset_i ? 0 : m_cnt);
    end
    @(posedge clk_i);
    apply();
    #1;
  endtask
  task automatic idle();
    bp.D_valid_i = 0; bp.D_PC_i = 0; bp.D_isBranch_i = 0; bp.D_isJump_i = 0;
    bp.D_isCall_i = 0; bp.D_isReturn_i = 0; bp.D_target_i = 0;
    bp.E_update_i = 0; bp.E_bhtIndex_i = 0; bp.E_taken_i = 0;
    bp.E_mispredict_i = 0; bp.E_rasPtr_i = 0; bp.E_rasCount_i = 0;
  endtask
  task automatic dec(input logic [31:0] pc, input bit br, input bit jmp, input bit call,
                     input bit ret, input logic [31:0] tgt);
    idle();
    bp.D_valid_i = 1; bp.D_PC_i = pc; bp.D_isBranch_i = br; bp.D_isJump_i = jmp;
    bp.D_isCall_i = call; bp.D_isReturn_i = ret; bp.D_target_i = tgt;
  endtask
  task automatic expect_pred(input string tag, input bit p, input logic [31:0] t);
    #1;
    chk(tag, 32'(bp.D_predictPC_o), 32'(p));
    if (p) chk({tag, "_tgt"}, bp.D_PCprediction_o, t);
  endtask
  initial begin
    n_cmp = 0; n_bad = 0; m_known = 0; m_ready = 0;
    idle();
    reset_i = 1;
    step();
    step();
    reset_i = 0;
    for (int i = 0; i < 7; i++) begin
      dec(32'(i * 4), 1, 0, 0, 0, 32'h200);
      bp.E_update_i = 1; bp.E_bhtIndex_i = BA'(5); bp.E_taken_i = 1;
      expect_pred("init_br", 0, 0);
      step();
    end
    reset_i = 1;
    idle();
    step();
    reset_i = 0;
    for (int i = 0; i < BHT; i++) begin
      dec(32'(i * 4), 1, 0, 0, 0, 32'h200);
      bp.E_update_i = 1; bp.E_bhtIndex_i = BA'(5); bp.E_taken_i = 1;
      expect_pred("sweep_br", 0, 0);
      chk("sweep_ready", 32'(bp.ready_o), 0);
      step();
    end
    chk("ready_up", 32'(bp.ready_o), 1);
    dec(32'h14, 1, 0, 0, 0, 32'h200);
    expect_pred("wnt_after_init", 0, 0);
    step();
    for (int k = 0; k < 6; k++) begin
      dec(pc_for(32'h40), 1, 0, 0, 0, 32'h880);
      bp.E_update_i = 1; bp.E_bhtIndex_i = BA'(32'h40); bp.E_taken_i = k < 4;
      expect_pred("ctr_read", k > 0, 32'h880);
      step();
      idle();
      #1;
      chk("hist", 32'(bp.D_bhtIndex_o), hist_exp[k]);
    end
    dec(pc_for(32'h40), 1, 0, 0, 0, 32'h880);
    expect_pred("ctr_final", 0, 0);
    step();
    dec(32'h1000, 0, 1, 1, 0, 32'h8000); expect_pred("call1", 1, 32'h8000); step();
    dec(32'h2000, 0, 1, 1, 0, 32'h8100); expect_pred("call2", 1, 32'h8100); step();
    dec(32'h3000, 0, 1, 0, 1, 32'h9000); expect_pred("ret1", 1, 32'h2004); step();
    dec(32'h3000, 0, 1, 0, 1, 32'h9000); expect_pred("ret2", 1, 32'h1004); step();
    dec(32'h3000, 0, 1, 0, 1, 32'h9000); expect_pred("ret3_empty", 0, 0); step();
    chk("empty_cnt", 32'(bp.D_rasCount_o), 0);
    for (int i = 1; i <= 5; i++) begin
      dec(32'(i * 16), 0, 1, 1, 0, 32'h700);
      step();
    end
    chk("ovf_cnt", 32'(bp.D_rasCount_o), 4);
    for (int i = 0; i < 4; i++) begin
      dec(32'h600, 0, 1, 0, 1, 0);
      expect_pred("ovf_ret", 1, ovf_exp[i]);
      step();
    end
    dec(32'h600, 0, 1, 0, 1, 0); expect_pred("ovf_empty", 0, 0); step();
    dec(32'h100, 0, 1, 1, 0, 32'h4000); step();
    cp_tp = m_tp; cp_cnt = m_cnt;
    chk("cp_cnt", 32'(bp.D_rasCount_o), 1);
    dec(32'h300, 0, 1, 1, 0, 32'h4000); step();
    dec(32'h380, 0, 1, 0, 1, 0); expect_pred("rs_ret", 1, 32'h304); step();
    dec(32'h500, 0, 1, 1, 0, 32'h4000); step();
    dec(32'h700, 0, 1, 1, 0, 32'h4000);
    bp.E_mispredict_i = 1; bp.E_rasPtr_i = RPB'(cp_tp); bp.E_rasCount_i = (RPB + 1)'(cp_cnt);
    step();
    idle();
    #1;
    chk("rs_ptr", 32'(bp.D_rasPtr_o), cp_tp);
    chk("rs_cnt", 32'(bp.D_rasCount_o), cp_cnt);
    dec(32'h780, 0, 1, 0, 1, 0); expect_pred("rs_ret_after", 1, 32'h104); step();
    for (int n = 0; n < 4000; n++) begin
      int r;
      idle();
      reset_i = $urandom_range(999) == 0;
      r = $urandom_range(7);
      if (!reset_i && $urandom_range(3) != 0)
        dec({22'd0, 8'($urandom_range(255)), 2'b00}, r < 4, r >= 4, r == 5 || r == 7,
            r >= 6, $urandom);
      bp.E_update_i = $urandom_range(1);
      bp.E_bhtIndex_i = BA'($urandom_range(31));
      bp.E_taken_i = $urandom_range(2) != 0;
      bp.E_mispredict_i = $urandom_range(15) == 0;
      bp.E_rasPtr_i = RPB'($urandom_range(RD - 1));
      bp.E_rasCount_i = (RPB + 1)'($urandom_range(RD));
      step();
    end
    reset_i = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
